// File: rtl/ula_pkg.sv
// ula_pkg: shared definitions for the ula sequencer slice.
//   - ALU operation codes and datapath widths
//   - sequencer FSM state encoding
//   - small opcode-decode helpers used by the sequencer
package ula_pkg;

  localparam int NREGS = 4;
  localparam int AW    = $clog2(NREGS);
  localparam int OPW   = 6;
  localparam int RESW  = 7;

  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_SUBI = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  // True for the five defined ALU codes; 000, 110 and 111 retire as errors.
  function automatic logic is_legal_op(input logic [2:0] op);
    logic legal;
    case (op)
      OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_MUL: legal = 1'b1;
      default:                                  legal = 1'b0;
    endcase
    return legal;
  endfunction

  // True when operand B comes from the instruction immediate instead of rs2.
  function automatic logic uses_imm(input logic [2:0] op);
    logic imm_sel;
    case (op)
      OP_ADDI, OP_SUBI: imm_sel = 1'b1;
      default:          imm_sel = 1'b0;
    endcase
    return imm_sel;
  endfunction

endpackage

// File: rtl/ula.sv
// ula: combinational 6-bit signed ALU.
//   A, B   in  6  signed operands (two's complement)
//   param  in  3  operation code (ADD/ADDI, SUB/SUBI, MUL; others yield 0)
//   S      out 7  result, truncated to 7 bits; overflow is not flagged
module ula
  import ula_pkg::*;
(
  input  logic [OPW-1:0]  A,
  input  logic [OPW-1:0]  B,
  input  logic [2:0]      param,
  output logic [RESW-1:0] S
);

  logic [RESW-1:0] a_ext;
  logic [RESW-1:0] b_ext;

  // Sign-extend to the result width. The low 7 bits of a product depend only
  // on the low 7 bits of the operands, so a 7x7 multiply gives the truncated
  // signed product directly.
  assign a_ext = {A[OPW-1], A};
  assign b_ext = {B[OPW-1], B};

  // Operation select.
  always_comb begin
    S = {RESW{1'b0}};
    case (param)
      OP_ADD, OP_ADDI: S = a_ext + b_ext;
      OP_SUB, OP_SUBI: S = a_ext - b_ext;
      OP_MUL:          S = a_ext * b_ext;
      default:         S = {RESW{1'b0}};
    endcase
  end

endmodule

// File: rtl/ula_regfile.sv
// ula_regfile: NREGS x W register file with asynchronous reset to zero.
//   clk, rst            clock, async active-high reset
//   we, waddr, wdata    synchronous write port
//   raddr1 / rdata1     async operand read port (low RW bits of the entry)
//   raddr2 / rdata2     async operand read port (low RW bits of the entry)
//   dbg_addr / dbg_data async debug read port (full W bits)
module ula_regfile #(
  parameter int NREGS = 4,
  parameter int W     = 7,
  parameter int RW    = 6,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr1,
  output logic [RW-1:0] rdata1,
  input  logic [AW-1:0] raddr2,
  output logic [RW-1:0] rdata2,
  input  logic [AW-1:0] dbg_addr,
  output logic [W-1:0]  dbg_data
);

  logic [W-1:0] regs [NREGS];

  // Storage: cleared on reset, single synchronous write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= {W{1'b0}};
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // Operand ports expose only the low RW bits: the ALU reinterprets them as signed.
  assign rdata1   = regs[raddr1][RW-1:0];
  assign rdata2   = regs[raddr2][RW-1:0];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/ula_seq.sv
// ula_seq: sequencer around the ula ALU and a 4-entry register file.
//   clk, rst        clock, async active-high reset
//   in_valid/ready  instruction handshake (ready only in IDLE, registered)
//   in_op           ALU code; in_rd/in_rs1/in_rs2 register indices; in_imm signed immediate
//   done            one-cycle pulse when a legal instruction writes back
//   err             one-cycle pulse when an illegal opcode retires
//   result          last written-back result, held until the next done
//   dbg_addr/data   combinational register-file debug read
// One instruction runs IDLE -> READ -> EXEC -> WB -> IDLE; done/err rise
// three clocks after the accepting edge.
module ula_seq
  import ula_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [AW-1:0]   in_rd,
  input  logic [AW-1:0]   in_rs1,
  input  logic [AW-1:0]   in_rs2,
  input  logic [OPW-1:0]  in_imm,
  output logic            done,
  output logic            err,
  output logic [RESW-1:0] result,
  input  logic [AW-1:0]   dbg_addr,
  output logic [RESW-1:0] dbg_data
);

  state_t          state;
  logic [2:0]      op_q;
  logic [AW-1:0]   rd_q;
  logic [AW-1:0]   rs1_q;
  logic [AW-1:0]   rs2_q;
  logic [OPW-1:0]  imm_q;
  logic [OPW-1:0]  opa_q;
  logic [OPW-1:0]  opb_q;
  logic [RESW-1:0] result_q;

  logic [OPW-1:0]  rdata1;
  logic [OPW-1:0]  rdata2;
  logic [RESW-1:0] alu_s;
  logic            rf_we;

  // Write-back happens on the edge that leaves WB, together with done/result.
  assign rf_we = (state == ST_WB) && is_legal_op(op_q);

  ula_regfile #(
    .NREGS (NREGS),
    .W     (RESW),
    .RW    (OPW),
    .AW    (AW)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (rf_we),
    .waddr    (rd_q),
    .wdata    (result_q),
    .raddr1   (rs1_q),
    .rdata1   (rdata1),
    .raddr2   (rs2_q),
    .rdata2   (rdata2),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  ula u_ula (
    .A     (opa_q),
    .B     (opb_q),
    .param (op_q),
    .S     (alu_s)
  );

  // Sequencer FSM with registered handshake and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_q     <= 3'b000;
      rd_q     <= {AW{1'b0}};
      rs1_q    <= {AW{1'b0}};
      rs2_q    <= {AW{1'b0}};
      imm_q    <= {OPW{1'b0}};
      opa_q    <= {OPW{1'b0}};
      opb_q    <= {OPW{1'b0}};
      result_q <= {RESW{1'b0}};
      result   <= {RESW{1'b0}};
      done     <= 1'b0;
      err      <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          // in_ready is still low on the first cycle out of reset, so no
          // instruction can be taken until it has been raised here.
          if (in_valid && in_ready) begin
            op_q     <= in_op;
            rd_q     <= in_rd;
            rs1_q    <= in_rs1;
            rs2_q    <= in_rs2;
            imm_q    <= in_imm;
            in_ready <= 1'b0;
            state    <= ST_READ;
          end else begin
            in_ready <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        ST_READ: begin
          // Reads see pre-write values: the previous WB has already completed.
          opa_q <= rdata1;
          opb_q <= uses_imm(op_q) ? imm_q : rdata2;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          result_q <= alu_s;
          state    <= ST_WB;
        end
        ST_WB: begin
          if (is_legal_op(op_q)) begin
            result <= result_q;
            done   <= 1'b1;
          end else begin
            err <= 1'b1;
          end
          in_ready <= 1'b1;
          state    <= ST_IDLE;
        end
        default: begin
          in_ready <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: directed self-checking bench for ula_seq.
// Each scenario task drives its stimulus and compares against hand-computed values.
module tb_ula_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic [1:0] in_rd;
  logic [1:0] in_rs1;
  logic [1:0] in_rs2;
  logic [5:0] in_imm;
  logic       done;
  logic       err;
  logic [6:0] result;
  logic [1:0] dbg_addr;
  logic [6:0] dbg_data;

  int vectors = 0;
  int miscompares = 0;

  ula_seq dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_rd    (in_rd),
    .in_rs1   (in_rs1),
    .in_rs2   (in_rs2),
    .in_imm   (in_imm),
    .done     (done),
    .err      (err),
    .result   (result),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  // Drives one instruction and reports what came out; it makes no judgement.
  // lat = clocks from the accepting edge to the first done/err, -1 if no pulse within 10 clocks.
  task automatic do_instr(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                          input logic [1:0] rs2, input logic [5:0] imm,
                          output int lat, output logic [6:0] res,
                          output logic dn, output logic er);
    int w;
    lat = -1; res = 7'd0; dn = 1'b0; er = 1'b0;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) return;
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (done || err) begin
        lat = i; res = result; dn = done; er = err;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_op = 3'b000; in_rd = 2'd0; in_rs1 = 2'd0;
    in_rs2 = 2'd0; in_imm = 6'd0; dbg_addr = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", in_ready); end
    vectors++;
    if (done !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL reset_pulses: done=%b err=%b want 0/0", done, err); end
    vectors++;
    if (result !== 7'd0) begin miscompares++; $display("FAIL reset_result: got %h want 00", result); end
    for (int r = 0; r < 4; r++) begin
      dbg_addr = r[1:0];
      #1;
      vectors++;
      if (dbg_data !== 7'd0) begin miscompares++; $display("FAIL reset_reg%0d: got %h want 00", r, dbg_data); end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL ready_at_release: got %b want 0", in_ready); end
    @(posedge clk);
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL ready_after_release: got %b want 1", in_ready); end
  endtask

  task automatic test_addi;
    int lat; logic [6:0] res; logic dn, er;
    do_instr(3'b010, 2'd1, 2'd0, 2'd0, 6'd5, lat, res, dn, er);
    vectors++;
    if (lat !== 3) begin miscompares++; $display("FAIL addi_latency: got %0d want 3", lat); end
    vectors++;
    if (res !== 7'd5 || dn !== 1'b1 || er !== 1'b0) begin miscompares++; $display("FAIL addi_result: got %h done=%b err=%b want 05/1/0", res, dn, er); end
    dbg_addr = 2'd1;
    #1;
    vectors++;
    if (dbg_data !== 7'd5) begin miscompares++; $display("FAIL addi_dbg_r1: got %h want 05", dbg_data); end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL addi_ready_back: got %b want 1", in_ready); end
    @(posedge clk);
    #1;
    vectors++;
    if (done !== 1'b0 || result !== 7'd5) begin miscompares++; $display("FAIL addi_pulse_hold: done=%b result=%h want 0/05", done, result); end
  endtask

  task automatic test_mul_sub;
    int lat; logic [6:0] res; logic dn, er;
    do_instr(3'b101, 2'd2, 2'd1, 2'd1, 6'd0, lat, res, dn, er);
    vectors++;
    if (lat !== 3 || res !== 7'd25 || dn !== 1'b1) begin miscompares++; $display("FAIL mul_5x5: lat=%0d res=%h done=%b want 3/19/1", lat, res, dn); end
    do_instr(3'b011, 2'd3, 2'd1, 2'd2, 6'd0, lat, res, dn, er);
    vectors++;
    if (res !== 7'b1101100 || dn !== 1'b1 || er !== 1'b0) begin miscompares++; $display("FAIL sub_neg: res=%h done=%b err=%b want 6c/1/0", res, dn, er); end
    dbg_addr = 2'd3;
    #1;
    vectors++;
    if (dbg_data !== 7'b1101100) begin miscompares++; $display("FAIL sub_dbg_r3: got %h want 6c", dbg_data); end
  endtask

  task automatic test_width_wrap;
    int lat; logic [6:0] res; logic dn, er;
    do_instr(3'b100, 2'd0, 2'd0, 2'd0, 6'b100000, lat, res, dn, er);
    vectors++;
    if (res !== 7'd32 || dn !== 1'b1) begin miscompares++; $display("FAIL subi_minus32: res=%h done=%b want 20/1", res, dn); end
    do_instr(3'b001, 2'd1, 2'd0, 2'd0, 6'd0, lat, res, dn, er);
    vectors++;
    if (res !== 7'b1000000 || dn !== 1'b1) begin miscompares++; $display("FAIL add_m32_m32: res=%h done=%b want 40/1", res, dn); end
    do_instr(3'b101, 2'd3, 2'd0, 2'd0, 6'd0, lat, res, dn, er);
    vectors++;
    if (res !== 7'd0 || dn !== 1'b1 || er !== 1'b0) begin miscompares++; $display("FAIL mul_trunc: res=%h done=%b err=%b want 00/1/0", res, dn, er); end
    dbg_addr = 2'd3;
    #1;
    vectors++;
    if (dbg_data !== 7'd0) begin miscompares++; $display("FAIL mul_dbg_r3: got %h want 00", dbg_data); end
  endtask

  task automatic test_illegal;
    int lat; logic [6:0] res; logic dn, er;
    do_instr(3'b111, 2'd1, 2'd0, 2'd0, 6'd3, lat, res, dn, er);
    vectors++;
    if (lat !== 3 || er !== 1'b1 || dn !== 1'b0) begin miscompares++; $display("FAIL illegal_err: lat=%0d err=%b done=%b want 3/1/0", lat, er, dn); end
    vectors++;
    if (res !== 7'd0) begin miscompares++; $display("FAIL illegal_result: got %h want 00", res); end
    dbg_addr = 2'd1;
    #1;
    vectors++;
    if (dbg_data !== 7'b1000000) begin miscompares++; $display("FAIL illegal_no_write: r1=%h want 40", dbg_data); end
    @(posedge clk);
    #1;
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("FAIL illegal_pulse: err=%b want 0", err); end
  endtask

  task automatic test_back_to_back;
    int n_done;
    n_done = 0;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL hold_ready_start: got %b want 1", in_ready); end
    // ADDI r2 = r2 + 1 (r2 = 25), valid held through every busy cycle.
    in_op = 3'b010; in_rd = 2'd2; in_rs1 = 2'd2; in_rs2 = 2'd0; in_imm = 6'd1;
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    in_valid = 1'b0;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL hold_ready_back: got %b want 1", in_ready); end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    vectors++;
    if (n_done !== 1) begin miscompares++; $display("FAIL hold_accept_once: done pulses=%0d want 1", n_done); end
    dbg_addr = 2'd2;
    #1;
    vectors++;
    if (dbg_data !== 7'd26) begin miscompares++; $display("FAIL hold_r2: got %0d want 26", dbg_data); end
  endtask

  task automatic test_reset_mid_op;
    int n_pulse;
    n_pulse = 0;
    @(negedge clk);
    in_op = 3'b010; in_rd = 2'd2; in_rs1 = 2'd0; in_rs2 = 2'd0; in_imm = 6'd7;
    in_valid = 1'b1;
    @(posedge clk);            // accept -> READ
    #1 in_valid = 1'b0;
    @(posedge clk);            // READ -> EXEC
    #1 rst = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL midrst_outputs: ready=%b done=%b want 0/0", in_ready, done); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_ready_release: got %b want 0", in_ready); end
    @(posedge clk);
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ready_next: got %b want 1", in_ready); end
    for (int i = 0; i < 5; i++) begin
      if (done || err) n_pulse++;
      @(posedge clk);
      #1;
    end
    vectors++;
    if (n_pulse !== 0) begin miscompares++; $display("FAIL midrst_no_pulse: pulses=%0d want 0", n_pulse); end
    dbg_addr = 2'd2;
    #1;
    vectors++;
    if (dbg_data !== 7'd0) begin miscompares++; $display("FAIL midrst_r2: got %h want 00", dbg_data); end
    vectors++;
    if (result !== 7'd0) begin miscompares++; $display("FAIL midrst_result: got %h want 00", result); end
  endtask

  initial begin
    test_reset;
    test_addi;
    test_mul_sub;
    test_width_wrap;
    test_illegal;
    test_back_to_back;
    test_reset_mid_op;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
